axi_arbiter_ysyx: RTL and testbench
===================================

Name: axi_arbiter_ysyx

Overview:
Two-master to one-slave AXI4 arbiter that shares the single memory/peripheral bus between the instruction fetch unit (master 0, IFU) and the load/store unit (master 1, LSU).
- Grants the bus to exactly one master for one full transaction, either read or write.
- Routes the request channels of the owner to the slave, and the slave's response channels back to the owner.
- Sits between the IFU/LSU AXI master ports and the top-level AXI master port (xbar/SoC).

Parameters:
- PERF_CNT_W, 32, width of the optional grant/stall counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- m0_ar*  in/out  AR channel of master 0: arvalid, araddr[31:0], arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0] in; arready out.
- m0_r*  out/in  R channel of master 0: rvalid, rdata[31:0], rresp[1:0], rlast, rid[3:0] out; rready in.
- m0_aw*/m0_w*/m0_b*  AW/W/B channels of master 0, same signal set as the LSU master port. Tied off by the IFU but fully routed.
- m1_ar*/m1_r*/m1_aw*/m1_w*/m1_b*  full AXI4 master-side channel set for master 1 (LSU).
- s_ar*/s_r*/s_aw*/s_w*/s_b*  full AXI4 channel set toward the slave (directions mirrored).

Behaviour:
- State machine states: IDLE, READ, WRITE. Registers: owner (0/1), last_grant (0/1).
- Reset values:
  - state = IDLE, owner = 0, last_grant = 0.
  - All valid/ready outputs = 0 on both master and slave sides.
  - Data/addr outputs = 0.
- Request: req_i = mi_arvalid | mi_awvalid.
- In IDLE with no request: stay in IDLE, drive all valids/readies to 0.
- In IDLE with request(s):
  - Choose the winner.
    - One requester: it wins.
    - Both request: winner = !last_grant (round-robin). After reset, master 1 wins the first tie.
  - Choose the direction: READ if the winner's arvalid = 1, else WRITE. A read wins over a write from the same master.
  - Update owner and last_grant to the winner; next state = READ or WRITE.
  - No grant is forwarded in IDLE. A request sampled at cycle N reaches the slave at cycle N+1.
- READ:
  - s_ar* = owner ar*; owner arready = s_arready.
  - owner r* = s_r*; s_rready = owner rready.
  - The non-owner sees arready/rvalid/awready/wready/bvalid = 0. Its valids are ignored but must stay asserted (AXI rule); it is served later.
  - The AW/W channels to the slave are driven inactive.
  - Exit to IDLE on the cycle after s_rvalid & s_rready & s_rlast. Bursts (arlen > 0) hold the grant until rlast.
- WRITE:
  - s_aw*, s_w* = owner's; owner awready/wready = slave's.
  - owner b* = s_b*; s_bready = owner bready.
  - AW and W may handshake in any order.
  - Exit to IDLE on the cycle after s_bvalid & s_bready.
- IDs pass through unchanged. Response routing uses owner only, never rid/bid.
- rresp/bresp are forwarded unmodified; error handling stays in the masters.
- Only one outstanding transaction system-wide. Minimum turnaround is 1 IDLE cycle between transactions.
- Reset asserted mid-transaction: immediately IDLE with all valids/readies 0. In-flight slave responses are dropped.
- Ready/data paths are purely combinational while granted. Only state/owner/last_grant are registered.

Optional Feature:
- Macro: AXI_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 and conflict_cnt, each [PERF_CNT_W-1:0]. All reset to 0.
  - grant_cntI increments on each IDLE -> READ/WRITE transition won by master I.
  - conflict_cnt increments on each IDLE cycle where both req_0 and req_1 = 1.
  - Counters wrap at 2^PERF_CNT_W.
- Undefined: no counters and no extra ports; function is otherwise identical.

Test Plan:
1. IFU only: m0 arvalid, araddr=0x8000_0000, arlen=0. Slave replies rdata=0x00000413, rlast=1.
   -> s_arvalid at cycle N+1; m0 gets rdata 0x00000413, rresp=00; state back to IDLE one cycle after the R handshake; m1 sees no readies.
2. LSU write: m1 awaddr=0x8000_0100, wdata=0xDEADBEEF, wstrb=1111; slave gives W handshake before AW.
   -> both forwarded; bresp=00 routed to m1; IDLE after the B handshake.
3. Simultaneous m0 read and m1 read after reset.
   -> m1 granted first; m0 granted next; a third tie goes to m1; last_grant alternates 1, 0, 1.
4. m0 burst arlen=3 while m1 arvalid is held high throughout.
   -> m0 receives 4 beats; m1 arready stays 0 until 1 cycle after rlast, then m1 is granted.
5. Slave returns rresp=10 to m1 load.
   -> m1 sees rresp=10 unchanged; arbiter returns to IDLE normally.
6. reset=0 asserted during WRITE after the AW handshake.
   -> all s_/m_ valids and readies are 0 in the same cycle; state = IDLE; with AXI_ARB_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/axi_arbiter_ysyx_if.sv
// Full AXI4 channel set (AR/R/AW/W/B) shared by master ports and the slave port.
// Wiring only, no latency; backpressure is the usual per-channel valid/ready.
interface axi_arbiter_ysyx_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/axi_arbiter_ysyx.sv
// Two-master (IFU=m0, LSU=m1) to one-slave AXI4 arbiter, one whole transaction per grant; AXI_ARB_PERF_CNT_EN adds counters.
// Latency: request seen in IDLE reaches the slave next cycle; at least one IDLE cycle between transactions.
// Backpressure: owner's channels are combinationally wired to the slave; the non-owner sees no readies/valids.
module axi_arbiter_ysyx #(
  parameter int PERF_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  axi_arbiter_ysyx_if.slave       m0,
  axi_arbiter_ysyx_if.slave       m1,
  axi_arbiter_ysyx_if.master      s
`ifdef AXI_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]   grant_cnt0,
  output logic [PERF_CNT_W-1:0]   grant_cnt1,
  output logic [PERF_CNT_W-1:0]   conflict_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;

  logic req0, req1, winner, win_ar;
  logic g0_rd, g1_rd, g0_wr, g1_wr;

  assign req0   = m0.arvalid | m0.awvalid;
  assign req1   = m1.arvalid | m1.awvalid;
  // Round-robin only matters on a tie; a lone requester always wins.
  assign winner = (req0 & req1) ? ~last_grant_q : req1;
  assign win_ar = winner ? m1.arvalid : m0.arvalid;

  assign g0_rd = (state_q == READ)  & ~owner_q;
  assign g1_rd = (state_q == READ)  &  owner_q;
  assign g0_wr = (state_q == WRITE) & ~owner_q;
  assign g1_wr = (state_q == WRITE) &  owner_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = win_ar ? READ : WRITE;
        end
      end
      READ:    if (s.rvalid & s.rready & s.rlast) state_d = IDLE;
      WRITE:   if (s.bvalid & s.bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave-side request channels: owner's signals while granted, zero otherwise.
  assign s.arvalid = (g0_rd & m0.arvalid) | (g1_rd & m1.arvalid);
  assign s.araddr  = g0_rd ? m0.araddr  : (g1_rd ? m1.araddr  : '0);
  assign s.arid    = g0_rd ? m0.arid    : (g1_rd ? m1.arid    : '0);
  assign s.arlen   = g0_rd ? m0.arlen   : (g1_rd ? m1.arlen   : '0);
  assign s.arsize  = g0_rd ? m0.arsize  : (g1_rd ? m1.arsize  : '0);
  assign s.arburst = g0_rd ? m0.arburst : (g1_rd ? m1.arburst : '0);
  assign s.rready  = (g0_rd & m0.rready) | (g1_rd & m1.rready);

  assign s.awvalid = (g0_wr & m0.awvalid) | (g1_wr & m1.awvalid);
  assign s.awaddr  = g0_wr ? m0.awaddr  : (g1_wr ? m1.awaddr  : '0);
  assign s.awid    = g0_wr ? m0.awid    : (g1_wr ? m1.awid    : '0);
  assign s.awlen   = g0_wr ? m0.awlen   : (g1_wr ? m1.awlen   : '0);
  assign s.awsize  = g0_wr ? m0.awsize  : (g1_wr ? m1.awsize  : '0);
  assign s.awburst = g0_wr ? m0.awburst : (g1_wr ? m1.awburst : '0);
  assign s.wvalid  = (g0_wr & m0.wvalid) | (g1_wr & m1.wvalid);
  assign s.wdata   = g0_wr ? m0.wdata   : (g1_wr ? m1.wdata   : '0);
  assign s.wstrb   = g0_wr ? m0.wstrb   : (g1_wr ? m1.wstrb   : '0);
  assign s.wlast   = (g0_wr & m0.wlast) | (g1_wr & m1.wlast);
  assign s.bready  = (g0_wr & m0.bready) | (g1_wr & m1.bready);

  // Responses follow owner_q only; rid/bid are passed through, never decoded.
  assign m0.arready = g0_rd & s.arready;
  assign m0.rvalid  = g0_rd & s.rvalid;
  assign m0.rdata   = g0_rd ? s.rdata : '0;
  assign m0.rresp   = g0_rd ? s.rresp : '0;
  assign m0.rlast   = g0_rd & s.rlast;
  assign m0.rid     = g0_rd ? s.rid   : '0;
  assign m0.awready = g0_wr & s.awready;
  assign m0.wready  = g0_wr & s.wready;
  assign m0.bvalid  = g0_wr & s.bvalid;
  assign m0.bresp   = g0_wr ? s.bresp : '0;
  assign m0.bid     = g0_wr ? s.bid   : '0;

  assign m1.arready = g1_rd & s.arready;
  assign m1.rvalid  = g1_rd & s.rvalid;
  assign m1.rdata   = g1_rd ? s.rdata : '0;
  assign m1.rresp   = g1_rd ? s.rresp : '0;
  assign m1.rlast   = g1_rd & s.rlast;
  assign m1.rid     = g1_rd ? s.rid   : '0;
  assign m1.awready = g1_wr & s.awready;
  assign m1.wready  = g1_wr & s.wready;
  assign m1.bvalid  = g1_wr & s.bvalid;
  assign m1.bresp   = g1_wr ? s.bresp : '0;
  assign m1.bid     = g1_wr ? s.bid   : '0;

`ifdef AXI_ARB_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [PERF_CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [PERF_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt0_d   = grant_cnt0_q;
    grant_cnt1_d   = grant_cnt1_q;
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == IDLE) begin
      if (req0 | req1) begin
        if (winner) grant_cnt1_d = grant_cnt1_q + PERF_CNT_W'(1);
        else        grant_cnt0_d = grant_cnt0_q + PERF_CNT_W'(1);
      end
      if (req0 & req1) conflict_cnt_d = conflict_cnt_q + PERF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_axi_arbiter_ysyx.sv
// Directed bench for axi_arbiter_ysyx: reset, single read/write, round-robin, bursts, error resp, mid-write reset.
module tb_axi_arbiter_ysyx;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  axi_arbiter_ysyx_if m0_bus ();
  axi_arbiter_ysyx_if m1_bus ();
  axi_arbiter_ysyx_if s_bus ();

`ifdef AXI_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  axi_arbiter_ysyx #(.PERF_CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
`ifdef AXI_ARB_PERF_CNT_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_bus.arvalid = 0; m0_bus.araddr = 0; m0_bus.arid = 0; m0_bus.arlen = 0; m0_bus.arsize = 0; m0_bus.arburst = 0;
    m0_bus.rready = 0; m0_bus.awvalid = 0; m0_bus.awaddr = 0; m0_bus.awid = 0; m0_bus.awlen = 0; m0_bus.awsize = 0;
    m0_bus.awburst = 0; m0_bus.wvalid = 0; m0_bus.wdata = 0; m0_bus.wstrb = 0; m0_bus.wlast = 0; m0_bus.bready = 0;
    m1_bus.arvalid = 0; m1_bus.araddr = 0; m1_bus.arid = 0; m1_bus.arlen = 0; m1_bus.arsize = 0; m1_bus.arburst = 0;
    m1_bus.rready = 0; m1_bus.awvalid = 0; m1_bus.awaddr = 0; m1_bus.awid = 0; m1_bus.awlen = 0; m1_bus.awsize = 0;
    m1_bus.awburst = 0; m1_bus.wvalid = 0; m1_bus.wdata = 0; m1_bus.wstrb = 0; m1_bus.wlast = 0; m1_bus.bready = 0;
    s_bus.arready = 0; s_bus.rvalid = 0; s_bus.rdata = 0; s_bus.rresp = 0; s_bus.rlast = 0; s_bus.rid = 0;
    s_bus.awready = 0; s_bus.wready = 0; s_bus.bvalid = 0; s_bus.bresp = 0; s_bus.bid = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #1;
    reset = 1'b0;
    m0_bus.arvalid = 1; m1_bus.awvalid = 1; s_bus.arready = 1; s_bus.rvalid = 1; s_bus.bvalid = 1; s_bus.rdata = 32'h1234;
    @(posedge clk);
    #2;
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, 0); end
    n_checks++; if (dut.owner_q !== 1'b0) begin n_fail++; $display("FAIL rst_owner: got %0d want %0d", dut.owner_q, 0); end
    n_checks++; if (dut.last_grant_q !== 1'b0) begin n_fail++; $display("FAIL rst_last_grant: got %0d want %0d", dut.last_grant_q, 0); end
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_s_arvalid: got %0d want %0d", s_bus.arvalid, 0); end
    n_checks++; if (s_bus.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_s_awvalid: got %0d want %0d", s_bus.awvalid, 0); end
    n_checks++; if (m0_bus.arready !== 1'b0) begin n_fail++; $display("FAIL rst_m0_arready: got %0d want %0d", m0_bus.arready, 0); end
    n_checks++; if (m0_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m0_rvalid: got %0d want %0d", m0_bus.rvalid, 0); end
    n_checks++; if (m1_bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m1_bvalid: got %0d want %0d", m1_bus.bvalid, 0); end
    n_checks++; if (m0_bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata: got %h want %h", m0_bus.rdata, 32'h0); end
    clear_inputs();
    reset = 1'b1;
    tick();
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL idle_no_req_state: got %0d want %0d", dut.state_q, 0); end
  endtask

  task automatic test_ifu_read();
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0000; m0_bus.arid = 4'h2; m0_bus.arlen = 0;
    m0_bus.arsize = 3'd2; m0_bus.arburst = 2'b01; m0_bus.rready = 1;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_no_grant_in_idle: got %0d want %0d", s_bus.arvalid, 0); end
    tick();
    n_checks++; if (s_bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL ifu_s_arvalid: got %0d want %0d", s_bus.arvalid, 1); end
    n_checks++; if (s_bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL ifu_s_araddr: got %h want %h", s_bus.araddr, 32'h8000_0000); end
    n_checks++; if (s_bus.arid !== 4'h2) begin n_fail++; $display("FAIL ifu_s_arid: got %h want %h", s_bus.arid, 4'h2); end
    s_bus.arready = 1;
    #1;
    n_checks++; if (m0_bus.arready !== 1'b1) begin n_fail++; $display("FAIL ifu_m0_arready: got %0d want %0d", m0_bus.arready, 1); end
    n_checks++; if (m1_bus.arready !== 1'b0) begin n_fail++; $display("FAIL ifu_m1_arready: got %0d want %0d", m1_bus.arready, 0); end
    tick();
    m0_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0413; s_bus.rresp = 2'b00; s_bus.rlast = 1; s_bus.rid = 4'h2;
    #1;
    n_checks++; if (m0_bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL ifu_m0_rvalid: got %0d want %0d", m0_bus.rvalid, 1); end
    n_checks++; if (m0_bus.rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL ifu_m0_rdata: got %h want %h", m0_bus.rdata, 32'h413); end
    n_checks++; if (m0_bus.rresp !== 2'b00) begin n_fail++; $display("FAIL ifu_m0_rresp: got %b want %b", m0_bus.rresp, 2'b00); end
    n_checks++; if (m0_bus.rid !== 4'h2) begin n_fail++; $display("FAIL ifu_m0_rid: got %h want %h", m0_bus.rid, 4'h2); end
    n_checks++; if (s_bus.rready !== 1'b1) begin n_fail++; $display("FAIL ifu_s_rready: got %0d want %0d", s_bus.rready, 1); end
    n_checks++; if (m1_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_m1_rvalid: got %0d want %0d", m1_bus.rvalid, 0); end
    n_checks++; if (s_bus.awvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_s_awvalid: got %0d want %0d", s_bus.awvalid, 0); end
    tick();
    s_bus.rvalid = 0; s_bus.rlast = 0; s_bus.rdata = 0;
    #1;
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL ifu_back_to_idle: got %0d want %0d", dut.state_q, 0); end
    n_checks++; if (m0_bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL ifu_m0_rvalid_idle: got %0d want %0d", m0_bus.rvalid, 0); end
  endtask

  task automatic test_lsu_write();
    m1_bus.awvalid = 1; m1_bus.awaddr = 32'h8000_0100; m1_bus.awid = 4'h5; m1_bus.awsize = 3'd2; m1_bus.awburst = 2'b01;
    m1_bus.wvalid = 1; m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wstrb = 4'hF; m1_bus.wlast = 1; m1_bus.bready = 1;
    #1;
    n_checks++; if (s_bus.awvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_grant_in_idle: got %0d want %0d", s_bus.awvalid, 0); end
    tick();
    n_checks++; if (s_bus.awvalid !== 1'b1) begin n_fail++; $display("FAIL wr_s_awvalid: got %0d want %0d", s_bus.awvalid, 1); end
    n_checks++; if (s_bus.awaddr !== 32'h8000_0100) begin n_fail++; $display("FAIL wr_s_awaddr: got %h want %h", s_bus.awaddr, 32'h8000_0100); end
    n_checks++; if (s_bus.wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_s_wvalid: got %0d want %0d", s_bus.wvalid, 1); end
    n_checks++; if (s_bus.wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_s_wdata: got %h want %h", s_bus.wdata, 32'hDEAD_BEEF); end
    n_checks++; if (s_bus.wstrb !== 4'hF) begin n_fail++; $display("FAIL wr_s_wstrb: got %h want %h", s_bus.wstrb, 4'hF); end
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL wr_s_arvalid: got %0d want %0d", s_bus.arvalid, 0); end
    s_bus.wready = 1;
    #1;
    n_checks++; if (m1_bus.wready !== 1'b1) begin n_fail++; $display("FAIL wr_m1_wready_first: got %0d want %0d", m1_bus.wready, 1); end
    n_checks++; if (m1_bus.awready !== 1'b0) begin n_fail++; $display("FAIL wr_m1_awready_early: got %0d want %0d", m1_bus.awready, 0); end
    n_checks++; if (m0_bus.wready !== 1'b0) begin n_fail++; $display("FAIL wr_m0_wready: got %0d want %0d", m0_bus.wready, 0); end
    tick();
    m1_bus.wvalid = 0; s_bus.wready = 0; s_bus.awready = 1;
    #1;
    n_checks++; if (m1_bus.awready !== 1'b1) begin n_fail++; $display("FAIL wr_m1_awready: got %0d want %0d", m1_bus.awready, 1); end
    tick();
    m1_bus.awvalid = 0; s_bus.awready = 0;
    s_bus.bvalid = 1; s_bus.bresp = 2'b00; s_bus.bid = 4'h5;
    #1;
    n_checks++; if (m1_bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL wr_m1_bvalid: got %0d want %0d", m1_bus.bvalid, 1); end
    n_checks++; if (m1_bus.bresp !== 2'b00) begin n_fail++; $display("FAIL wr_m1_bresp: got %b want %b", m1_bus.bresp, 2'b00); end
    n_checks++; if (m1_bus.bid !== 4'h5) begin n_fail++; $display("FAIL wr_m1_bid: got %h want %h", m1_bus.bid, 4'h5); end
    n_checks++; if (s_bus.bready !== 1'b1) begin n_fail++; $display("FAIL wr_s_bready: got %0d want %0d", s_bus.bready, 1); end
    n_checks++; if (m0_bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_m0_bvalid: got %0d want %0d", m0_bus.bvalid, 0); end
    tick();
    s_bus.bvalid = 0; s_bus.bid = 0;
    #1;
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL wr_back_to_idle: got %0d want %0d", dut.state_q, 0); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_owner;
    exp_owner = 3'b101;
    apply_reset();
    m0_bus.arvalid = 1; m0_bus.araddr = 32'hA000_0000; m0_bus.rready = 1;
    m1_bus.arvalid = 1; m1_bus.araddr = 32'hB000_0000; m1_bus.rready = 1;
    for (int g = 0; g < 3; g++) begin
      tick();
      s_bus.arready = 1;
      #1;
      n_checks++; if (s_bus.araddr !== (exp_owner[g] ? 32'hB000_0000 : 32'hA000_0000)) begin n_fail++; $display("FAIL rr_araddr_%0d: got %h want owner %0d", g, s_bus.araddr, exp_owner[g]); end
      n_checks++; if (m1_bus.arready !== exp_owner[g]) begin n_fail++; $display("FAIL rr_m1_arready_%0d: got %0d want %0d", g, m1_bus.arready, exp_owner[g]); end
      n_checks++; if (m0_bus.arready !== !exp_owner[g]) begin n_fail++; $display("FAIL rr_m0_arready_%0d: got %0d want %0d", g, m0_bus.arready, !exp_owner[g]); end
      n_checks++; if (dut.last_grant_q !== exp_owner[g]) begin n_fail++; $display("FAIL rr_last_grant_%0d: got %0d want %0d", g, dut.last_grant_q, exp_owner[g]); end
      tick();
      s_bus.arready = 0; s_bus.rvalid = 1; s_bus.rlast = 1;
      #1;
      n_checks++; if (m1_bus.rvalid !== exp_owner[g]) begin n_fail++; $display("FAIL rr_m1_rvalid_%0d: got %0d want %0d", g, m1_bus.rvalid, exp_owner[g]); end
      tick();
      s_bus.rvalid = 0; s_bus.rlast = 0;
      #1;
      n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL rr_idle_%0d: got %0d want %0d", g, dut.state_q, 0); end
    end
`ifdef AXI_ARB_PERF_CNT_EN
    n_checks++; if (grant_cnt0 !== 32'd1) begin n_fail++; $display("FAIL rr_grant_cnt0: got %0d want %0d", grant_cnt0, 1); end
    n_checks++; if (grant_cnt1 !== 32'd2) begin n_fail++; $display("FAIL rr_grant_cnt1: got %0d want %0d", grant_cnt1, 2); end
    n_checks++; if (conflict_cnt !== 32'd3) begin n_fail++; $display("FAIL rr_conflict_cnt: got %0d want %0d", conflict_cnt, 3); end
`endif
  endtask

  // Entered in IDLE with both masters requesting and last_grant = 1, so m0 wins the tie.
  task automatic test_burst_hold();
    m0_bus.arlen = 8'd3; m0_bus.araddr = 32'hC000_0000;
    tick();
    s_bus.arready = 1;
    #1;
    n_checks++; if (m0_bus.arready !== 1'b1) begin n_fail++; $display("FAIL burst_m0_arready: got %0d want %0d", m0_bus.arready, 1); end
    n_checks++; if (s_bus.arlen !== 8'd3) begin n_fail++; $display("FAIL burst_s_arlen: got %0d want %0d", s_bus.arlen, 3); end
    tick();
    m0_bus.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      s_bus.rvalid = 1; s_bus.rdata = 32'h100 + i; s_bus.rlast = (i == 3);
      #1;
      n_checks++; if (m0_bus.rdata !== 32'h100 + i) begin n_fail++; $display("FAIL burst_beat_%0d: got %h want %h", i, m0_bus.rdata, 32'h100 + i); end
      n_checks++; if (m1_bus.arready !== 1'b0) begin n_fail++; $display("FAIL burst_m1_arready_%0d: got %0d want %0d", i, m1_bus.arready, 0); end
      tick();
    end
    s_bus.rvalid = 0; s_bus.rlast = 0; s_bus.rdata = 0;
    #1;
    n_checks++; if (m1_bus.arready !== 1'b0) begin n_fail++; $display("FAIL burst_m1_arready_idle: got %0d want %0d", m1_bus.arready, 0); end
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL burst_idle_after_rlast: got %0d want %0d", dut.state_q, 0); end
    tick();
    n_checks++; if (m1_bus.arready !== 1'b1) begin n_fail++; $display("FAIL burst_m1_granted: got %0d want %0d", m1_bus.arready, 1); end
    n_checks++; if (s_bus.araddr !== 32'hB000_0000) begin n_fail++; $display("FAIL burst_m1_araddr: got %h want %h", s_bus.araddr, 32'hB000_0000); end
    tick();
    m1_bus.arvalid = 0; s_bus.arready = 0; s_bus.rvalid = 1; s_bus.rlast = 1;
    tick();
    s_bus.rvalid = 0; s_bus.rlast = 0;
    clear_inputs();
  endtask

  task automatic test_rresp_err();
    m1_bus.arvalid = 1; m1_bus.araddr = 32'h8000_0200; m1_bus.arid = 4'h7; m1_bus.rready = 1;
    tick();
    s_bus.arready = 1;
    tick();
    m1_bus.arvalid = 0; s_bus.arready = 0;
    s_bus.rvalid = 1; s_bus.rresp = 2'b10; s_bus.rlast = 1; s_bus.rid = 4'h7;
    #1;
    n_checks++; if (m1_bus.rresp !== 2'b10) begin n_fail++; $display("FAIL err_m1_rresp: got %b want %b", m1_bus.rresp, 2'b10); end
    n_checks++; if (m1_bus.rid !== 4'h7) begin n_fail++; $display("FAIL err_m1_rid: got %h want %h", m1_bus.rid, 4'h7); end
    n_checks++; if (m1_bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL err_m1_rvalid: got %0d want %0d", m1_bus.rvalid, 1); end
    tick();
    s_bus.rvalid = 0; s_bus.rresp = 0; s_bus.rlast = 0; s_bus.rid = 0;
    #1;
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL err_back_to_idle: got %0d want %0d", dut.state_q, 0); end
    m0_bus.arvalid = 1; m0_bus.araddr = 32'h8000_0004;
    tick();
    n_checks++; if (s_bus.araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL err_next_grant_addr: got %h want %h", s_bus.araddr, 32'h8000_0004); end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    m1_bus.awvalid = 1; m1_bus.awaddr = 32'h8000_0300; m1_bus.wvalid = 1; m1_bus.wdata = 32'h5555_AAAA;
    m1_bus.wstrb = 4'hF; m1_bus.wlast = 1; m1_bus.bready = 1;
    tick();
    s_bus.awready = 1;
    #1;
    n_checks++; if (m1_bus.awready !== 1'b1) begin n_fail++; $display("FAIL mid_m1_awready: got %0d want %0d", m1_bus.awready, 1); end
    tick();
    m1_bus.awvalid = 0; s_bus.awready = 0; s_bus.wready = 1;
    #1;
    n_checks++; if (m1_bus.wready !== 1'b1) begin n_fail++; $display("FAIL mid_m1_wready_pre: got %0d want %0d", m1_bus.wready, 1); end
    s_bus.bvalid = 1;
    reset = 1'b0;
    #1;
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", dut.state_q, 0); end
    n_checks++; if (s_bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL mid_s_wvalid: got %0d want %0d", s_bus.wvalid, 0); end
    n_checks++; if (s_bus.bready !== 1'b0) begin n_fail++; $display("FAIL mid_s_bready: got %0d want %0d", s_bus.bready, 0); end
    n_checks++; if (m1_bus.wready !== 1'b0) begin n_fail++; $display("FAIL mid_m1_wready: got %0d want %0d", m1_bus.wready, 0); end
    n_checks++; if (m1_bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL mid_m1_bvalid: got %0d want %0d", m1_bus.bvalid, 0); end
    n_checks++; if (s_bus.wdata !== 32'h0) begin n_fail++; $display("FAIL mid_s_wdata: got %h want %h", s_bus.wdata, 32'h0); end
`ifdef AXI_ARB_PERF_CNT_EN
    n_checks++; if (grant_cnt1 !== 32'd0) begin n_fail++; $display("FAIL mid_grant_cnt1: got %0d want %0d", grant_cnt1, 0); end
    n_checks++; if (conflict_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_conflict_cnt: got %0d want %0d", conflict_cnt, 0); end
`endif
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_round_robin();
    test_burst_hold();
    test_rresp_err();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
